// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: count/pointer width functions, pointer wrap and the status bundle.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Explicit compare so non-power-of-two depths wrap correctly.
  function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_pointer.sv
// Modulo-DEPTH pointer with enable, synchronous clear and async active-low reset.
module fifo_sync_pointer
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = PTR_W'(ptr_wrap_inc(32'(ptr_q), DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count, thresholds, sticky flags and flush.
// Define FIFO_SYNC_FWFT_EN for first-word fall-through; default is registered read.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned DEPTH              = 8,
  parameter int unsigned ALMOST_FULL_LEVEL  = DEPTH - 1,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            write_enable,
  input  logic [DATA_WIDTH-1:0]           write_data,
  output logic                            full,
  output logic                            almost_full,
  input  logic                            read_enable,
  output logic [DATA_WIDTH-1:0]           read_data,
  output logic                            read_valid,
  output logic                            empty,
  output logic                            almost_empty,
  output logic [count_width(DEPTH)-1:0]   count,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int unsigned CNT_W = count_width(DEPTH);
  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_ok, rd_ok;
  fifo_status_t          status;

  always_comb begin
    status.full         = (count_q == DEPTH_C);
    status.empty        = (count_q == '0);
    status.almost_full  = (32'(count_q) >= ALMOST_FULL_LEVEL);
    status.almost_empty = (32'(count_q) <= ALMOST_EMPTY_LEVEL);
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
  end

  // Requests during a flush are dropped entirely, including their flag effects.
  assign wr_ok = write_enable & ~status.full  & ~clear;
  assign rd_ok = read_enable  & ~status.empty & ~clear;

  fifo_sync_pointer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (clear),
    .en_i    (wr_ok),
    .ptr_o   (wr_ptr)
  );

  fifo_sync_pointer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (clear),
    .en_i    (rd_ok),
    .ptr_o   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr] <= write_data;
    end
  end

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok && !rd_ok) begin
        count_d = count_q + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count_d = count_q - 1'b1;
      end
      if (write_enable && status.full) begin
        overflow_d = 1'b1;
      end
      if (read_enable && status.empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_SYNC_FWFT_EN
  assign read_data  = status.empty ? '0 : mem_q[rd_ptr];
  assign read_valid = ~status.empty;
`else
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  read_valid_q, read_valid_d;

  always_comb begin
    read_data_d  = rd_ok ? mem_q[rd_ptr] : read_data_q;
    read_valid_d = rd_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
`endif

  assign full         = status.full;
  assign almost_full  = status.almost_full;
  assign empty        = status.empty;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign count        = count_q;

endmodule
